alu_operand_stage: RTL and testbench

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

---
 rtl/alu_operand_pkg.sv | 18 +
 rtl/operand_fwd_mux.sv | 35 +++
 rtl/alu_operand_stage.sv | 127 ++++++++++++
 tb/tb_alu_operand_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_operand_pkg.sv
// rtl/alu_operand_pkg.sv - shared constants for the ALU operand stage
package alu_operand_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_IMMW  = 16;
  localparam int DEF_AW    = 5;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// rtl/operand_fwd_mux.sv - forward compare/select for one source operand
module operand_fwd_mux
  import alu_operand_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
) (
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] rf_data,
  input  logic             ex_wr_en,
  input  logic [AW-1:0]    ex_wr_addr,
  input  logic [WIDTH-1:0] ex_wr_data,
  input  logic             mem_wr_en,
  input  logic [AW-1:0]    mem_wr_addr,
  input  logic [WIDTH-1:0] mem_wr_data,
  output logic [WIDTH-1:0] data,
  output logic [1:0]       fwd
);

  // Register 0 is hardwired, so a pending write to it must never be forwarded.
  always_comb begin
    data = rf_data;
    fwd  = FWD_RF;
    if (addr != '0) begin
      if (ex_wr_en && (ex_wr_addr == addr)) begin
        data = ex_wr_data;
        fwd  = FWD_EX;
      end else if (mem_wr_en && (mem_wr_addr == addr)) begin
        data = mem_wr_data;
        fwd  = FWD_MEM;
      end
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - operand forwarding/extension with 2-entry skid buffer
module alu_operand_stage
  import alu_operand_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IMMW  = DEF_IMMW,
  parameter int AW    = DEF_AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    rs_addr,
  input  logic [AW-1:0]    rt_addr,
  input  logic [WIDTH-1:0] rf_rd1,
  input  logic [WIDTH-1:0] rf_rd2,
  input  logic [IMMW-1:0]  imm,
  input  logic             imm_zext,
  input  logic             alu_in_sel,
  input  logic             ex_wr_en,
  input  logic [AW-1:0]    ex_wr_addr,
  input  logic [WIDTH-1:0] ex_wr_data,
  input  logic             mem_wr_en,
  input  logic [AW-1:0]    mem_wr_addr,
  input  logic [WIDTH-1:0] mem_wr_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] store_data,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  buf_state_t state;

  logic [WIDTH-1:0] rs_val, rt_val, ext_imm, new_b;
  logic [1:0]       rs_fwd, rt_fwd;
  logic             accept, issue;

  logic [WIDTH-1:0] tail_a, tail_b, tail_sd;
  logic [1:0]       tail_fa, tail_fb;

  operand_fwd_mux #(.WIDTH(WIDTH), .AW(AW)) u_rs_mux (
    .addr(rs_addr), .rf_data(rf_rd1),
    .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .data(rs_val), .fwd(rs_fwd)
  );

  operand_fwd_mux #(.WIDTH(WIDTH), .AW(AW)) u_rt_mux (
    .addr(rt_addr), .rf_data(rf_rd2),
    .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .data(rt_val), .fwd(rt_fwd)
  );

  assign ext_imm   = imm_zext ? WIDTH'(imm) : WIDTH'($signed(imm));
  assign new_b     = alu_in_sel ? ext_imm : rt_val;
  assign in_ready  = (state != ST_TWO);
  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign issue     = out_valid && out_ready;

  // The head entry registers are the outputs; the tail only fills while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      alu_a      <= '0;
      alu_b      <= '0;
      store_data <= '0;
      fwd_a      <= FWD_RF;
      fwd_b      <= FWD_RF;
      tail_a     <= '0;
      tail_b     <= '0;
      tail_sd    <= '0;
      tail_fa    <= FWD_RF;
      tail_fb    <= FWD_RF;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            alu_a      <= rs_val;
            alu_b      <= new_b;
            store_data <= rt_val;
            fwd_a      <= rs_fwd;
            fwd_b      <= rt_fwd;
            state      <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && issue) begin
            alu_a      <= rs_val;
            alu_b      <= new_b;
            store_data <= rt_val;
            fwd_a      <= rs_fwd;
            fwd_b      <= rt_fwd;
          end else if (accept) begin
            tail_a  <= rs_val;
            tail_b  <= new_b;
            tail_sd <= rt_val;
            tail_fa <= rs_fwd;
            tail_fb <= rt_fwd;
            state   <= ST_TWO;
          end else if (issue) begin
            state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (issue) begin
            alu_a      <= tail_a;
            alu_b      <= tail_b;
            store_data <= tail_sd;
            fwd_a      <= tail_fa;
            fwd_b      <= tail_fb;
            state      <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - self-checking bench for alu_operand_stage
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, imm_zext, alu_in_sel;
  logic [4:0]  rs_addr, rt_addr, ex_wr_addr, mem_wr_addr;
  logic [31:0] rf_rd1, rf_rd2, ex_wr_data, mem_wr_data;
  logic [15:0] imm;
  logic        ex_wr_en, mem_wr_en, flush, out_valid, out_ready;
  logic [31:0] alu_a, alu_b, store_data;
  logic [1:0]  fwd_a, fwd_b;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] a, b, sd;
    logic [1:0]  fa, fb;
  } exp_t;

  exp_t q[$];
  bit   armed = 0;
  bit   zero_out = 0;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .imm(imm), .imm_zext(imm_zext), .alu_in_sel(alu_in_sel),
    .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .store_data(store_data),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void pick(input logic [4:0] addr, input logic [31:0] rf,
                               output logic [31:0] d, output logic [1:0] c);
    d = rf;
    c = 2'd0;
    if (addr != 0 && ex_wr_en && ex_wr_addr == addr) begin
      d = ex_wr_data; c = 2'd1;
    end else if (addr != 0 && mem_wr_en && mem_wr_addr == addr) begin
      d = mem_wr_data; c = 2'd2;
    end
  endfunction

  function automatic exp_t model_entry();
    exp_t   e;
    longint v;
    pick(rs_addr, rf_rd1, e.a, e.fa);
    pick(rt_addr, rf_rd2, e.sd, e.fb);
    v = longint'(imm);
    if (!imm_zext && imm >= 16'h8000) v = v - 65536;
    e.b = alu_in_sel ? v[31:0] : e.sd;
    return e;
  endfunction

  // Model: a plain FIFO of at most two expected entries.
  always @(posedge clk) begin
    bit   acc, iss;
    exp_t e;
    if (!rst_n) begin
      q.delete();
      zero_out = 1;
      armed = 1;
    end else if (flush) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() < 2);
      iss = (q.size() > 0) && out_ready;
      e = model_entry();
      if (iss) q.delete(0);
      if (acc) begin
        q.push_back(e);
        zero_out = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("alu_a", alu_a, q[0].a);
        chk("alu_b", alu_b, q[0].b);
        chk("store_data", store_data, q[0].sd);
        chk("fwd_a", 32'(fwd_a), 32'(q[0].fa));
        chk("fwd_b", 32'(fwd_b), 32'(q[0].fb));
      end else if (zero_out) begin
        chk("rst_outs", alu_a | alu_b | store_data | 32'(fwd_a) | 32'(fwd_b), 32'd0);
      end
    end
  end

  task automatic idle();
    in_valid = 0; rs_addr = 0; rt_addr = 0; rf_rd1 = 0; rf_rd2 = 0;
    imm = 0; imm_zext = 0; alu_in_sel = 0; ex_wr_en = 0; ex_wr_addr = 0;
    ex_wr_data = 0; mem_wr_en = 0; mem_wr_addr = 0; mem_wr_data = 0; flush = 0;
  endtask

  initial begin
    idle();
    out_ready = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    chk("lit_reset_in_ready", 32'(in_ready), 32'd1);
    chk("lit_reset_out_valid", 32'(out_valid), 32'd0);
    chk("lit_reset_alu_a", alu_a, 32'd0);

    // EX beats MEM on the same address
    in_valid = 1; rs_addr = 3; rf_rd1 = 32'h1111;
    ex_wr_en = 1; ex_wr_addr = 3; ex_wr_data = 32'hAAAA0001;
    mem_wr_en = 1; mem_wr_addr = 3; mem_wr_data = 32'h55;
    @(negedge clk);
    idle();
    chk("lit_ex_prio_out_valid", 32'(out_valid), 32'd1);
    chk("lit_ex_prio_alu_a", alu_a, 32'hAAAA0001);
    chk("lit_ex_prio_fwd_a", 32'(fwd_a), 32'd1);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;

    // Register 0 never forwards
    in_valid = 1; rt_addr = 0; rf_rd2 = 0;
    ex_wr_en = 1; ex_wr_addr = 0; ex_wr_data = 32'hDEAD_BEEF;
    mem_wr_en = 1; mem_wr_addr = 0; mem_wr_data = 32'hCAFE_0000;
    @(negedge clk);
    idle();
    chk("lit_r0_store_data", store_data, 32'd0);
    chk("lit_r0_fwd_b", 32'(fwd_b), 32'd0);
    out_ready = 1;

    // Immediate extension, back to back with issue
    in_valid = 1; imm = 16'h8000; imm_zext = 0; alu_in_sel = 1;
    @(negedge clk);
    chk("lit_imm_sext", alu_b, 32'hFFFF8000);
    imm_zext = 1;
    @(negedge clk);
    chk("lit_imm_zext", alu_b, 32'h00008000);
    idle();
    rs_addr = 5; rf_rd1 = 32'h77; mem_wr_en = 1; mem_wr_addr = 5; mem_wr_data = 32'h1234;
    ex_wr_en = 1; ex_wr_addr = 6; ex_wr_data = 32'h9; in_valid = 1;
    @(negedge clk);
    idle();
    chk("lit_mem_fwd_a", 32'(fwd_a), 32'd2);
    chk("lit_mem_alu_a", alu_a, 32'h1234);
    @(negedge clk);
    out_ready = 0;

    // Stall: three back-to-back accepts, third held until release
    in_valid = 1; rs_addr = 1; rf_rd1 = 32'hA1;
    @(negedge clk);
    rf_rd1 = 32'hA2;
    @(negedge clk);
    chk("lit_stall_in_ready", 32'(in_ready), 32'd0);
    rf_rd1 = 32'hA3; ex_wr_en = 1; ex_wr_addr = 1; ex_wr_data = 32'hE3;
    @(negedge clk);
    chk("lit_stall_head", alu_a, 32'hA1);
    out_ready = 1;
    @(negedge clk);
    chk("lit_release_second", alu_a, 32'hA2);
    @(negedge clk);
    idle();
    chk("lit_release_third", alu_a, 32'hE3);
    chk("lit_release_third_fwd", 32'(fwd_a), 32'd1);
    @(negedge clk);
    out_ready = 0;

    // Flush from TWO with a concurrent accept
    in_valid = 1; rs_addr = 2; rf_rd1 = 32'hB1;
    @(negedge clk);
    rf_rd1 = 32'hB2;
    @(negedge clk);
    flush = 1; rf_rd1 = 32'hB3; out_ready = 1;
    @(negedge clk);
    idle();
    chk("lit_flush_out_valid", 32'(out_valid), 32'd0);
    chk("lit_flush_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("lit_flush_stays_empty", 32'(out_valid), 32'd0);
    out_ready = 0;

    // Reset while holding one entry
    in_valid = 1; rs_addr = 4; rf_rd1 = 32'hC4; rt_addr = 4; rf_rd2 = 32'hC4;
    @(negedge clk);
    rst_n = 0; flush = 1;
    @(negedge clk);
    rst_n = 1;
    idle();
    chk("lit_rst_out_valid", 32'(out_valid), 32'd0);
    chk("lit_rst_in_ready", 32'(in_ready), 32'd1);
    chk("lit_rst_outs", alu_a | alu_b | store_data | 32'(fwd_a) | 32'(fwd_b), 32'd0);

    // Mixed traffic on a small address space to exercise every forward case
    for (int i = 0; i < 60; i++) begin
      in_valid    = 1'($urandom_range(0, 1));
      out_ready   = 1'($urandom_range(0, 1));
      rs_addr     = 5'($urandom_range(0, 3));
      rt_addr     = 5'($urandom_range(0, 3));
      rf_rd1      = $urandom;
      rf_rd2      = $urandom;
      imm         = 16'($urandom);
      imm_zext    = 1'($urandom_range(0, 1));
      alu_in_sel  = 1'($urandom_range(0, 1));
      ex_wr_en    = 1'($urandom_range(0, 1));
      ex_wr_addr  = 5'($urandom_range(0, 3));
      ex_wr_data  = $urandom;
      mem_wr_en   = 1'($urandom_range(0, 1));
      mem_wr_addr = 5'($urandom_range(0, 3));
      mem_wr_data = $urandom;
      flush       = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    idle();
    out_ready = 1;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
